// File: rtl/add_rc_controller_pkg.sv
// rtl/add_rc_controller_pkg.sv - shared Keccak AddRc constants and controller state encoding
//
// Purpose : round-pipeline geometry defaults and the sequencer state type,
//           imported by the AddRc controller and its sub-blocks.
// Contents: SLICES, ROUNDS, ROUND_W defaults; ctrlState_t (3-bit encoding).

package add_rc_controller_pkg;

   localparam int SLICES  = 64;   // slices per Keccak state
   localparam int ROUNDS  = 24;   // legal round indices are 0..ROUNDS-1
   localparam int ROUND_W = 5;    // width of round index / cycleNum

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      WAIT_IN = 3'd2,
      OUT     = 3'd3,
      DONE    = 3'd4
   } ctrlState_t;

endpackage

// File: rtl/add_rc_controller_register.sv
// rtl/add_rc_controller_register.sv - N-bit enabled register with synchronous clear
//
// Purpose : generic holding register; used to latch the round index.
// Ports   : clk  in  1   rising-edge clock
//           rst  in  1   synchronous active-high clear (q <= 0)
//           en   in  1   load enable
//           d    in  N   data in
//           q    out N   registered data

module add_rc_controller_register #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/add_rc_controller.sv
// rtl/add_rc_controller.sv - sequencing FSM for the Keccak AddRc (iota) datapath
//
// Purpose : per round, latch the round index, clear the slice counter and output
//           register, then walk all slices with one load per upstream handshake
//           and one counter advance per downstream acceptance; pulse done at end.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           start, round             round request and its index (IDLE only)
//           busy, done, roundErr     status: in round / end pulse / bad index pulse
//           inValid, inReady         upstream slice handshake
//           outValid, outReady       downstream slice handshake
//           sliceCntCo               datapath counter at last slice
//           sliceCntEn, sliceCntClr  datapath counter control
//           ldReg, clrReg            datapath output register control
//           cycleNum                 latched round index for the RC lookup

module add_rc_controller
   import add_rc_controller_pkg::*;
#(
   parameter int ROUNDS  = add_rc_controller_pkg::ROUNDS,
   parameter int ROUND_W = add_rc_controller_pkg::ROUND_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ROUND_W-1:0] round,
   output logic               busy,
   output logic               done,
   output logic               roundErr,
   input  logic               inValid,
   output logic               inReady,
   output logic               outValid,
   input  logic               outReady,
   input  logic               sliceCntCo,
   output logic               sliceCntEn,
   output logic               sliceCntClr,
   output logic               ldReg,
   output logic               clrReg,
   output logic [ROUND_W-1:0] cycleNum
);

   // One extra bit so ROUNDS == 2**ROUND_W still compares correctly.
   localparam logic [ROUND_W:0] ROUNDS_EXT = ROUNDS[ROUND_W:0];

   ctrlState_t state;
   ctrlState_t nextState;

   logic roundOk;
   logic acceptStart;
   logic rejectStart;

   assign roundOk     = ({1'b0, round} < ROUNDS_EXT);
   assign acceptStart = (state == IDLE) && start && roundOk;
   assign rejectStart = (state == IDLE) && start && !roundOk;

   // Round index only moves on an accepted start, so it is stable all round.
   add_rc_controller_register #(.N(ROUND_W)) uCycleNum (
      .clk (clk),
      .rst (rst),
      .en  (acceptStart),
      .d   (round),
      .q   (cycleNum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         roundErr <= 1'b0;
      end else begin
         state    <= nextState;
         roundErr <= rejectStart;
      end
   end

   always_comb begin
      nextState   = state;
      busy        = 1'b0;
      done        = 1'b0;
      inReady     = 1'b0;
      outValid    = 1'b0;
      sliceCntEn  = 1'b0;
      sliceCntClr = 1'b0;
      ldReg       = 1'b0;
      clrReg      = 1'b0;

      unique case (state)
         IDLE: begin
            if (acceptStart) begin
               nextState = CLEAR;
            end
         end
         CLEAR: begin
            busy        = 1'b1;
            sliceCntClr = 1'b1;
            clrReg      = 1'b1;
            nextState   = WAIT_IN;
         end
         WAIT_IN: begin
            busy    = 1'b1;
            inReady = 1'b1;
            if (inValid) begin
               ldReg     = 1'b1;
               nextState = OUT;
            end
         end
         OUT: begin
            // Counter steps only after downstream takes the slice, keeping
            // the RC bit used at load aligned with the slice being loaded.
            busy     = 1'b1;
            outValid = 1'b1;
            if (outReady) begin
               if (sliceCntCo) begin
                  nextState = DONE;
               end else begin
                  sliceCntEn = 1'b1;
                  nextState  = WAIT_IN;
               end
            end
         end
         DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            sliceCntClr = 1'b1;
            nextState   = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_add_rc_controller.sv
// tb/tb_add_rc_controller.sv - self-checking scoreboard bench for add_rc_controller

module tb_add_rc_controller;
   import add_rc_controller_pkg::*;

   localparam int LATENCY = 2 * SLICES + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] round = 5'd0;
   logic       inValid = 1'b0;
   logic       outReady = 1'b0;
   logic       sliceCntCo;
   logic       busy, done, roundErr, inReady, outValid;
   logic       sliceCntEn, sliceCntClr, ldReg, clrReg;
   logic [4:0] cycleNum;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;
   int cnt     = 0;
   int ldCnt   = 0;
   int enCnt   = 0;
   int clrCnt  = 0;
   logic [4:0] curRound = 5'd0;
   bit stalling = 1'b0;

   typedef struct {
      logic [4:0] r;
      int         expDone;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int       sliceQ[$];

   add_rc_controller dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .round       (round),
      .busy        (busy),
      .done        (done),
      .roundErr    (roundErr),
      .inValid     (inValid),
      .inReady     (inReady),
      .outValid    (outValid),
      .outReady    (outReady),
      .sliceCntCo  (sliceCntCo),
      .sliceCntEn  (sliceCntEn),
      .sliceCntClr (sliceCntClr),
      .ldReg       (ldReg),
      .clrReg      (clrReg),
      .cycleNum    (cycleNum)
   );

   always #5 clk = ~clk;

   // Datapath slice counter model; deliberately not cleared by rst.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sliceCntClr)     cnt <= 0;
      else if (sliceCntEn) cnt <= cnt + 1;
   end
   assign sliceCntCo = (cnt == SLICES - 1);

   task automatic checkEq(input string tag, input int got, input int exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int outVec();
      return int'({busy, done, roundErr, inReady, outValid,
                   sliceCntEn, sliceCntClr, ldReg, clrReg});
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (ldReg || sliceCntEn) checkEq("mealyExclusive", int'(ldReg & sliceCntEn), 0);
         if (ldReg) begin
            ldCnt++;
            sliceQ.push_back(cnt);
            checkEq("cycleNumAtLoad", int'(cycleNum), int'(curRound));
         end
         if (outValid && outReady) begin
            if (sliceQ.size() == 0) checkEq("sliceQueue", sliceQ.size(), 1);
            else checkEq("sliceOrder", cnt, sliceQ.pop_front());
         end
         if (sliceCntEn) enCnt++;
         if (clrReg) clrCnt++;
         if (stalling) begin
            checkEq("stallOutValid", int'(outValid), 1);
            checkEq("stallLdReg", int'(ldReg), 0);
            checkEq("stallCntEn", int'(sliceCntEn), 0);
         end
         if (done) begin
            if (sbQ.size() == 0) begin
               checkEq("spuriousDone", int'(done), 0);
            end else begin
               sbEntry_t e;
               e = sbQ.pop_front();
               checkEq("doneCycle", cyc, e.expDone);
               checkEq("ldCount", ldCnt, SLICES);
               checkEq("enCount", enCnt, SLICES - 1);
               checkEq("clearCount", clrCnt, 1);
               checkEq("busyAtDone", int'(busy), 1);
               checkEq("cycleNumAtDone", int'(cycleNum), int'(e.r));
               checkEq("slicesDrained", sliceQ.size(), 0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one round with optional stall, ignored-start and reset-abort events.
   task automatic runRound(input logic [4:0] r, input int stallAt,
                           input int intrAt, input int abortAt);
      bit finished = 1'b0;
      bit stallDone = 1'b0;
      bit intrDone = 1'b0;
      int guard = 0;
      ldCnt = 0; enCnt = 0; clrCnt = 0;
      curRound = r;
      if (abortAt < 0) sbQ.push_back('{r: r, expDone: cyc + LATENCY + ((stallAt >= 0) ? 5 : 0)});
      start = 1'b1;
      round = r;
      tick();
      start = 1'b0;
      while (!finished && guard < 600) begin
         guard++;
         if (done) begin
            finished = 1'b1;
            tick();
         end else if (stallAt >= 0 && !stallDone && outValid && cnt == stallAt) begin
            outReady = 1'b0;
            stalling = 1'b1;
            repeat (5) tick();
            outReady = 1'b1;
            stalling = 1'b0;
            stallDone = 1'b1;
         end else if (intrAt >= 0 && !intrDone && inReady && cnt == intrAt) begin
            start = 1'b1;
            round = 5'd5;
            tick();
            start = 1'b0;
            round = r;
            intrDone = 1'b1;
         end else if (abortAt >= 0 && inReady && cnt == abortAt) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            sliceQ.delete();
            checkEq("abortOutputs", outVec(), 0);
            checkEq("abortCycleNum", int'(cycleNum), 0);
            repeat (LATENCY + 10) tick();
            checkEq("abortNoBusy", int'(busy), 0);
            return;
         end else begin
            tick();
         end
      end
      checkEq("doneTimeout", int'(finished), 1);
   endtask

   initial begin
      inValid  = 1'b1;
      outReady = 1'b1;
      repeat (3) tick();
      checkEq("resetOutputs", outVec(), 0);
      checkEq("resetCycleNum", int'(cycleNum), 0);
      rst = 1'b0;
      tick();
      checkEq("idleOutputs", outVec(), 0);

      runRound(5'd0, -1, -1, -1);
      runRound(5'd23, 10, -1, -1);

      start = 1'b1;
      round = 5'd24;
      tick();
      start = 1'b0;
      checkEq("roundErrPulse", int'(roundErr), 1);
      checkEq("roundErrBusy", int'(busy), 0);
      checkEq("roundErrCycleNum", int'(cycleNum), 23);
      tick();
      checkEq("roundErrOneCycle", int'(roundErr), 0);
      checkEq("roundErrStillIdle", int'(busy), 0);
      tick();

      runRound(5'd3, -1, 20, -1);
      runRound(5'd12, -1, -1, 10);
      runRound(5'd7, -1, -1, -1);
      runRound(5'd22, -1, -1, -1);

      repeat (5) tick();
      checkEq("scoreboardEmpty", sbQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
